// File: rtl/transmit_scheduler.sv
// Walks the board RAM square by square and hands each engine-owned piece to
// the piece transmitter, holding it until the ray-propagation network accepts.
module transmit_scheduler #(
  parameter int LAST_SQ = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       engine_color,
  output logic [5:0] bd_addr,
  input  logic [5:0] bd_data,
  output logic [5:0] piece_reg,
  output logic [5:0] pos_reg,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [6:0] piece_count
);

  typedef enum logic [2:0] {IDLE, READ, EVAL, ISSUE, DONE} state_t;

  localparam logic [5:0] LAST = 6'(LAST_SQ);

  state_t state;
  logic   color;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      color       <= 1'b0;
      bd_addr     <= '0;
      piece_reg   <= '0;
      pos_reg     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      piece_count <= '0;
    end else begin
      done <= 1'b0;
      // Cancel wins over everything, including a same-cycle handshake.
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        tx_valid  <= 1'b0;
        piece_reg <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            color       <= engine_color;
            bd_addr     <= '0;
            piece_count <= '0;
            busy        <= 1'b1;
            state       <= READ;
          end
          READ: state <= EVAL;
          EVAL: begin
            if (bd_data != 6'd0 && bd_data[5] == color) begin
              piece_reg <= bd_data;
              pos_reg   <= bd_addr;
              tx_valid  <= 1'b1;
              state     <= ISSUE;
            end else if (bd_addr == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bd_addr <= bd_addr + 6'd1;
              state   <= READ;
            end
          end
          ISSUE: if (tx_ready) begin
            tx_valid    <= 1'b0;
            piece_reg   <= '0;
            piece_count <= piece_count + 7'd1;
            if (bd_addr == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bd_addr <= bd_addr + 6'd1;
              state   <= READ;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_transmit_scheduler.sv
// Directed bench for transmit_scheduler: stimulus pushes expected issues and
// done counts into queues, a monitor pops and compares them.
module tb_transmit_scheduler;
  logic       clk = 1'b0;
  logic       reset, start, abort, engine_color, tx_ready;
  logic [5:0] bd_addr, bd_data, piece_reg, pos_reg;
  logic       tx_valid, busy, done;
  logic [6:0] piece_count;

  transmit_scheduler #(.LAST_SQ(63)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .engine_color(engine_color), .bd_addr(bd_addr), .bd_data(bd_data),
    .piece_reg(piece_reg), .pos_reg(pos_reg), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .piece_count(piece_count)
  );

  always #5 clk = ~clk;

  logic [5:0] mem [64];
  always @(posedge clk) bd_data <= mem[bd_addr];

  typedef struct packed {logic [5:0] piece; logic [5:0] pos;} tx_t;
  tx_t exp_tx[$];
  int  exp_done[$];
  int  checks = 0, errors = 0;
  int  n, last_hs, held, bad;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, when inputs and outputs are settled.
  initial begin
    tx_t e;
    int  c;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (tx_valid && tx_ready && !abort) begin
          if (exp_tx.size() == 0) check("unexpected_issue", 1, 0);
          else begin
            e = exp_tx.pop_front();
            check("issue_piece", int'(piece_reg), int'(e.piece));
            check("issue_pos", int'(pos_reg), int'(e.pos));
          end
        end
        if (done) begin
          if (exp_done.size() == 0) check("unexpected_done", 1, 0);
          else begin
            c = exp_done.pop_front();
            check("done_count", int'(piece_count), c);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_board();
    for (int i = 0; i < 64; i++) mem[i] = 6'd0;
  endtask

  // Leaves the bench at the falling edge of cycle 1 (first cycle after start is taken).
  task automatic start_scan(input logic color);
    engine_color = color;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
  endtask

  task automatic run_to_done();
    last_hs = -1;
    while (!done && n < 400) begin
      if (tx_valid && tx_ready) last_hs = n;
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    while (!tx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) check("valid_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; engine_color = 1'b0; tx_ready = 1'b0;
    clear_board();
    #12;
    check("rst_busy", busy, 0);
    check("rst_addr", bd_addr, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_count", piece_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Empty board: 64 squares at 2 cycles each.
    tx_ready = 1'b1;
    exp_done.push_back(0);
    start_scan(1'b1);
    bad = 0;
    while (!done && n < 400) begin
      if (n <= 128 && int'(bd_addr) != (n - 1) / 2) bad++;
      @(negedge clk);
      n++;
    end
    check("empty_done_cycle", n, 129);
    check("empty_addr_seq", bad, 0);
    check("empty_busy_at_done", busy, 1);
    @(negedge clk);
    check("empty_idle_busy", busy, 0);
    check("empty_done_pulse", done, 0);

    // White to move: rook sq0 and pawn sq63 issued, black pawn sq5 skipped.
    mem[0] = 6'b110000; mem[5] = 6'b000010; mem[63] = 6'b100010;
    exp_tx.push_back({6'b110000, 6'd0});
    exp_tx.push_back({6'b100010, 6'd63});
    exp_done.push_back(2);
    start_scan(1'b1);
    run_to_done();
    check("white_done_cycle", n, 131);
    check("white_done_after_hs", n - last_hs, 1);
    check("white_count", piece_count, 2);
    @(negedge clk);

    // Same board, black to move.
    exp_tx.push_back({6'b000010, 6'd5});
    exp_done.push_back(1);
    start_scan(1'b0);
    run_to_done();
    check("black_done_cycle", n, 130);
    check("black_count", piece_count, 1);
    @(negedge clk);

    // Backpressure on a knight at sq10.
    clear_board();
    mem[10] = 6'b100001;
    tx_ready = 1'b0;
    exp_tx.push_back({6'b100001, 6'd10});
    exp_done.push_back(1);
    start_scan(1'b1);
    wait_valid();
    check("bp_first_valid", n, 23);
    held = 0; bad = 0;
    repeat (5) begin
      if (tx_valid && piece_reg == 6'b100001 && pos_reg == 6'd10) held++;
      if (piece_count != 7'd0) bad++;
      @(negedge clk);
      n++;
    end
    if (tx_valid && piece_reg == 6'b100001 && pos_reg == 6'd10) held++;
    tx_ready = 1'b1;
    @(negedge clk);
    n++;
    check("bp_held_cycles", held, 6);
    check("bp_count_stalled", bad, 0);
    check("bp_resume_addr", bd_addr, 11);
    check("bp_valid_drop", tx_valid, 0);
    check("bp_piece_clear", piece_reg, 0);
    check("bp_count", piece_count, 1);
    run_to_done();
    check("bp_done_cycle", n, 135);
    @(negedge clk);

    // Abort with a simultaneous handshake on the second issue.
    clear_board();
    mem[0] = 6'b110000; mem[63] = 6'b100010;
    exp_tx.push_back({6'b110000, 6'd0});
    start_scan(1'b1);
    repeat (3) begin @(negedge clk); n++; end
    tx_ready = 1'b0;
    wait_valid();
    check("abort_valid_cycle", n, 130);
    abort = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; tx_ready = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", tx_valid, 0);
    check("abort_piece", piece_reg, 0);
    check("abort_count", piece_count, 1);
    check("abort_done", done, 0);
    // start together with abort in IDLE must stay idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);
    repeat (2) @(negedge clk);
    tx_ready = 1'b1;
    exp_tx.push_back({6'b110000, 6'd0});
    exp_tx.push_back({6'b100010, 6'd63});
    exp_done.push_back(2);
    start_scan(1'b1);
    check("restart_addr", bd_addr, 0);
    check("restart_count", piece_count, 0);
    run_to_done();
    check("restart_done_cycle", n, 131);
    @(negedge clk);

    // start while busy is ignored; async reset mid-scan.
    clear_board();
    start_scan(1'b1);
    repeat (9) begin @(negedge clk); n++; end
    check("busy_addr_before", bd_addr, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n++;
    check("busy_start_ignored", bd_addr, 5);
    #2 reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_addr", bd_addr, 0);
    check("async_count", piece_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", busy, 0);

    check("leftover_issues", exp_tx.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
